// File: rtl/bus_pkg.sv
// Shared bus definitions: destination codes, increment bit indices and the
// data-RAM write FSM state encoding. Also used by the bus mux and control unit.
package bus_pkg;

    localparam int DATA_W_DEF = 16;

    // Destination codes carried on ld_sel; 8..15 decode to nothing.
    localparam logic [3:0] DEST_NONE = 4'd0;
    localparam logic [3:0] DEST_AR   = 4'd1;
    localparam logic [3:0] DEST_PC   = 4'd2;
    localparam logic [3:0] DEST_DR   = 4'd3;
    localparam logic [3:0] DEST_IR   = 4'd4;
    localparam logic [3:0] DEST_R    = 4'd5;
    localparam logic [3:0] DEST_AC   = 4'd6;
    localparam logic [3:0] DEST_DRAM = 4'd7;

    // Bit positions inside the one-hot inc_sel vector.
    localparam int INC_PC = 0;
    localparam int INC_AR = 1;
    localparam int INC_R  = 2;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_e;

endpackage

// File: rtl/bus_dram_wr_fsm.sv
// Single-outstanding write handshake to data RAM with an ack timeout.
// Requests arriving while a write is outstanding are dropped and flagged.
module bus_dram_wr_fsm
    import bus_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACK_TMO = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              dram_ack,
    output logic [DATA_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    output logic              wr_busy,
    output logic              wr_done,
    output logic              wr_err,
    output logic              wr_accept
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

    wr_state_e  state, state_nxt;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) state <= WR_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WR_IDLE: if (start)               state_nxt = WR_WAIT;
            WR_WAIT: if (dram_ack || tmo_hit) state_nxt = WR_IDLE;
            default:                          state_nxt = WR_IDLE;
        endcase
    end

    // An ack seen while still IDLE never counts; only WAIT can accept.
    always_comb begin
        dram_we   = (state == WR_WAIT);
        wr_busy   = (state != WR_IDLE);
        wr_accept = (state == WR_WAIT) && dram_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt    <= '0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            wr_done <= (state == WR_WAIT) && dram_ack;
            if (state == WR_IDLE) begin
                tmo_cnt <= '0;
                if (start) begin
                    dram_addr  <= wr_addr;
                    dram_wdata <= wr_data;
                end
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if ((state == WR_WAIT) && (start || (!dram_ack && tmo_hit)))
                wr_err <= 1'b1;
        end
    end

endmodule

// File: rtl/bus_dest_regs.sv
// Bus receive side: decodes ld_sel and loads AR/PC/DR/IR/R/AC or issues a data-RAM write.
// Define BUS_DEST_AR_AUTOINC_EN to step AR by one on every accepted RAM write.
module bus_dest_regs
    import bus_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACK_TMO = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_data,
    input  logic [3:0]        ld_sel,
    input  logic [2:0]        inc_sel,
    input  logic              clr_ac,
    output logic [DATA_W-1:0] ar,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] dr,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] r,
    output logic [DATA_W-1:0] ac,
    output logic              ac_zero,
    output logic [DATA_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    input  logic              dram_ack,
    output logic              wr_busy,
    output logic              wr_done,
    output logic              wr_err
);

`ifdef BUS_DEST_AR_AUTOINC_EN
    localparam bit AR_AUTOINC = 1'b1;
`else
    localparam bit AR_AUTOINC = 1'b0;
`endif

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic              wr_accept;
    logic [DATA_W-1:0] ac_nxt;

    // ac_zero is computed from next-state AC so the flag lands with its value.
    always_comb begin
        ac_nxt = ac;
        if (clr_ac)                 ac_nxt = '0;
        else if (ld_sel == DEST_AC) ac_nxt = bus_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ar      <= '0;
            pc      <= '0;
            dr      <= '0;
            ir      <= '0;
            r       <= '0;
            ac      <= '0;
            ac_zero <= 1'b1;
        end else begin
            // Auto-increment only fills in when nothing else touches AR this cycle.
            if (ld_sel == DEST_AR)                                ar <= bus_data;
            else if (inc_sel[INC_AR] || (AR_AUTOINC && wr_accept)) ar <= ar + ONE;

            if (ld_sel == DEST_PC)    pc <= bus_data;
            else if (inc_sel[INC_PC]) pc <= pc + ONE;

            if (ld_sel == DEST_R)    r <= bus_data;
            else if (inc_sel[INC_R]) r <= r + ONE;

            if (ld_sel == DEST_DR) dr <= bus_data;
            if (ld_sel == DEST_IR) ir <= bus_data;

            ac      <= ac_nxt;
            ac_zero <= (ac_nxt == '0);
        end
    end

    bus_dram_wr_fsm #(
        .DATA_W  (DATA_W),
        .ACK_TMO (ACK_TMO)
    ) u_wr_fsm (
        .clock      (clock),
        .reset      (reset),
        .start      (ld_sel == DEST_DRAM),
        .wr_addr    (ar),
        .wr_data    (bus_data),
        .dram_ack   (dram_ack),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_we    (dram_we),
        .wr_busy    (wr_busy),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .wr_accept  (wr_accept)
    );

endmodule
